// File: rtl/dv_test_seq.sv
`default_nettype none
// ============================================================================
// Module      : dv_test_seq
// Description : Test sequencer FSM. It waits for DUT activation, runs the
//               stimulus under a watchdog, drains, then reports pass or fail.
// Revision    : 1.0 - initial release
// ============================================================================
module dv_test_seq #(
    parameter int unsigned ACTIVE_TIMEOUT = 1000,
    parameter int unsigned RUN_TIMEOUT    = 10000,
    parameter int unsigned DRAIN_CYCLES   = 16
) (
    input  logic        clk1,
    input  logic        nreset,
    input  logic        dut_active,
    input  logic        stim_done,
    input  logic        test_done,
    input  logic        error,
    output logic        start,
    output logic        stim_en,
    output logic        finish,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [2:0]  state,
    output logic [31:0] run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_ACTIVE = 3'd1,
        S_RUN         = 3'd2,
        S_DRAIN       = 3'd3,
        S_PASS        = 3'd4,
        S_FAIL        = 3'd5
    } state_t;

    localparam logic [31:0] C_ACTIVE_LAST = 32'(ACTIVE_TIMEOUT - 1);
    localparam logic [31:0] C_RUN_LAST    = 32'(RUN_TIMEOUT - 1);
    localparam logic [31:0] C_DRAIN_LAST  = 32'(DRAIN_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_rel;
    logic [31:0] r_wait_cnt;
    logic [31:0] r_wd_cnt;
    logic [31:0] r_drain_cnt;
    logic [31:0] r_run_cycles;
    logic        r_stim_seen;
    logic        r_test_seen;
    logic        r_timeout;
    logic        r_finish;
    logic        w_set_timeout;
    logic        w_complete;
    logic        w_in_run;
    logic        w_terminal;
    logic        w_next_terminal;

    assign w_in_run        = (r_state == S_RUN);
    assign w_complete      = (r_stim_seen | stim_done) & (r_test_seen | test_done);
    assign w_terminal      = (r_state == S_PASS) || (r_state == S_FAIL);
    assign w_next_terminal = (w_next_state == S_PASS) || (w_next_state == S_FAIL);

    // Release qualifier: together with the state register this makes IDLE
    // exit on the second rising edge after nreset deasserts.
    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            r_rel <= 1'b0;
        end else begin
            r_rel <= 1'b1;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rel) begin
                    w_next_state = S_WAIT_ACTIVE;
                end
            end
            S_WAIT_ACTIVE: begin
                if (dut_active) begin
                    w_next_state = S_RUN;
                end else if (r_wait_cnt == C_ACTIVE_LAST) begin
                    w_next_state  = S_FAIL;
                    w_set_timeout = 1'b1;
                end
            end
            S_RUN: begin
                // Priority: error, then completion, then watchdog expiry.
                if (error) begin
                    w_next_state = S_FAIL;
                end else if (w_complete) begin
                    w_next_state = S_DRAIN;
                end else if (r_wd_cnt == C_RUN_LAST) begin
                    w_next_state  = S_FAIL;
                    w_set_timeout = 1'b1;
                end
            end
            S_DRAIN: begin
                if (error) begin
                    w_next_state = S_FAIL;
                end else if (r_drain_cnt == C_DRAIN_LAST) begin
                    w_next_state = S_PASS;
                end
            end
            S_PASS, S_FAIL: begin
                w_next_state = r_state;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b0;
            r_finish  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_timeout <= r_timeout | w_set_timeout;
            r_finish  <= w_next_terminal & ~w_terminal;
        end
    end

    // Per-state counters and flags clear whenever their state is not active,
    // so each is zero on the first cycle of its state.
    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            r_wait_cnt  <= '0;
            r_wd_cnt    <= '0;
            r_drain_cnt <= '0;
            r_stim_seen <= 1'b0;
            r_test_seen <= 1'b0;
        end else begin
            r_wait_cnt  <= (r_state == S_WAIT_ACTIVE) ? r_wait_cnt + 32'd1 : 32'd0;
            r_wd_cnt    <= w_in_run ? r_wd_cnt + 32'd1 : 32'd0;
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 32'd1 : 32'd0;
            r_stim_seen <= w_in_run & (r_stim_seen | stim_done);
            r_test_seen <= w_in_run & (r_test_seen | test_done);
        end
    end

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            r_run_cycles <= '0;
        end else if (w_in_run && (r_run_cycles != 32'hFFFF_FFFF)) begin
            r_run_cycles <= r_run_cycles + 32'd1;
        end
    end

    assign start      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign stim_en    = w_in_run & ~r_stim_seen;
    assign finish     = r_finish;
    assign pass       = (r_state == S_PASS);
    assign fail       = (r_state == S_FAIL);
    assign timeout    = r_timeout;
    assign state      = r_state;
    assign run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_dv_test_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dv_test_seq
// Description : Self-checking bench for dv_test_seq; scenario table with a
//               scoreboard of expected terminal/abort results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dv_test_seq;

    localparam int ST_IDLE  = 0;
    localparam int ST_WAIT  = 1;
    localparam int ST_RUN   = 2;
    localparam int ST_DRAIN = 3;
    localparam int ST_PASS  = 4;
    localparam int ST_FAIL  = 5;
    localparam int BUDGET   = 400;

    logic        clk1;
    logic        nreset;
    logic        dut_active;
    logic        stim_done;
    logic        test_done;
    logic        error;
    logic        start;
    logic        stim_en;
    logic        finish;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [2:0]  state;
    logic [31:0] run_cycles;

    int checks = 0;
    int errors = 0;

    dv_test_seq #(
        .ACTIVE_TIMEOUT (20),
        .RUN_TIMEOUT    (100),
        .DRAIN_CYCLES   (16)
    ) u_dut (
        .clk1       (clk1),
        .nreset     (nreset),
        .dut_active (dut_active),
        .stim_done  (stim_done),
        .test_done  (test_done),
        .error      (error),
        .start      (start),
        .stim_en    (stim_en),
        .finish     (finish),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .state      (state),
        .run_cycles (run_cycles)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        int active_at;   // WAIT_ACTIVE index where dut_active rises (-1 never)
        int stim_at;     // RUN index where stim_done rises (-1 never)
        int test_at;     // RUN index where test_done rises (-1 never)
        bit err_wait;    // error held high in IDLE and WAIT_ACTIVE
        int err_run;
        int err_drain;
        int abort_run;   // RUN index where nreset is pulsed low
        int abort_drain;
        int exp_state;
        bit exp_timeout;
        int exp_run;
        int exp_wait;
        int exp_drain;
    } vec_t;

    typedef struct {
        int          idx;
        logic [2:0]  st;
        logic        start_v;
        logic        stim_en_v;
        logic        finish_v;
        logic        pass_v;
        logic        fail_v;
        logic        timeout_v;
        logic [31:0] run_v;
        int          wait_c;
        int          drain_c;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[14];

    function automatic vec_t mk(input int aa, input int sa, input int ta, input bit ew,
                                input int er, input int ed, input int ar, input int ad,
                                input int es, input bit et, input int erun,
                                input int ew_c, input int ed_c);
        vec_t v;
        v.active_at = aa; v.stim_at = sa; v.test_at = ta; v.err_wait = ew;
        v.err_run = er; v.err_drain = ed; v.abort_run = ar; v.abort_drain = ad;
        v.exp_state = es; v.exp_timeout = et; v.exp_run = erun;
        v.exp_wait = ew_c; v.exp_drain = ed_c;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_compare(input int wait_c, input int drain_c);
        sb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no expected entry, expected one");
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_state", e.idx), 32'(state), 32'(e.st));
            chk($sformatf("v%0d_start", e.idx), 32'(start), 32'(e.start_v));
            chk($sformatf("v%0d_stim_en", e.idx), 32'(stim_en), 32'(e.stim_en_v));
            chk($sformatf("v%0d_finish", e.idx), 32'(finish), 32'(e.finish_v));
            chk($sformatf("v%0d_pass", e.idx), 32'(pass), 32'(e.pass_v));
            chk($sformatf("v%0d_fail", e.idx), 32'(fail), 32'(e.fail_v));
            chk($sformatf("v%0d_timeout", e.idx), 32'(timeout), 32'(e.timeout_v));
            chk($sformatf("v%0d_run_cycles", e.idx), run_cycles, e.run_v);
            chk($sformatf("v%0d_wait_cycles", e.idx), 32'(wait_c), 32'(e.wait_c));
            chk($sformatf("v%0d_drain_cycles", e.idx), 32'(drain_c), 32'(e.drain_c));
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        sb_t        e;
        int         edges, run_idx, wait_idx, drain_idx, budget;
        int         start_bad, stim_bad, extra_fin, hold_bad;
        bit         done, aborted, stim_seen_m;
        logic [2:0] st;

        nreset     = 1'b0;
        dut_active = 1'b0;
        stim_done  = 1'b0;
        test_done  = 1'b0;
        error      = v.err_wait;
        repeat (3) tick();
        chk($sformatf("v%0d_reset_flags", idx),
            32'({state, start, stim_en, finish, pass, fail, timeout}), 32'd0);
        chk($sformatf("v%0d_reset_run_cycles", idx), run_cycles, 32'd0);

        e.idx       = idx;
        e.st        = 3'(v.exp_state);
        e.start_v   = 1'b0;
        e.stim_en_v = 1'b0;
        e.finish_v  = (v.exp_state == ST_PASS) || (v.exp_state == ST_FAIL);
        e.pass_v    = (v.exp_state == ST_PASS);
        e.fail_v    = (v.exp_state == ST_FAIL);
        e.timeout_v = v.exp_timeout;
        e.run_v     = 32'(v.exp_run);
        e.wait_c    = v.exp_wait;
        e.drain_c   = v.exp_drain;
        sb.push_back(e);

        nreset = 1'b1;
        edges  = 0;
        while ((state == 3'(ST_IDLE)) && (edges < 10)) begin
            tick();
            edges++;
        end
        chk($sformatf("v%0d_idle_exit_edge", idx), 32'(edges), 32'd2);

        run_idx = 0; wait_idx = 0; drain_idx = 0; budget = 0;
        start_bad = 0; stim_bad = 0; done = 1'b0; aborted = 1'b0; stim_seen_m = 1'b0;
        while (!done) begin
            st         = state;
            dut_active = (v.active_at >= 0) && (wait_idx >= v.active_at);
            stim_done  = (v.stim_at >= 0) && (run_idx >= v.stim_at);
            test_done  = (v.test_at >= 0) && (run_idx >= v.test_at);
            error      = (v.err_wait && (st == 3'(ST_WAIT))) ||
                         ((st == 3'(ST_RUN)) && (run_idx == v.err_run)) ||
                         ((st == 3'(ST_DRAIN)) && (drain_idx == v.err_drain));

            if (start !== ((st == 3'(ST_RUN)) || (st == 3'(ST_DRAIN)))) start_bad++;
            if (st == 3'(ST_RUN)) begin
                if (stim_en !== !stim_seen_m) stim_bad++;
            end else if (stim_en !== 1'b0) begin
                stim_bad++;
            end

            if (((st == 3'(ST_RUN)) && (run_idx == v.abort_run)) ||
                ((st == 3'(ST_DRAIN)) && (drain_idx == v.abort_drain))) begin
                nreset = 1'b0;
                #2;
                sb_compare(wait_idx, drain_idx);
                done    = 1'b1;
                aborted = 1'b1;
            end else if ((st == 3'(ST_PASS)) || (st == 3'(ST_FAIL))) begin
                sb_compare(wait_idx, drain_idx);
                done = 1'b1;
            end else if (budget >= BUDGET) begin
                checks++;
                errors++;
                $display("FAIL v%0d_budget: got no terminal state after %0d cycles, expected state %0d",
                         idx, budget, v.exp_state);
                if (sb.size() != 0) void'(sb.pop_front());
                done    = 1'b1;
                aborted = 1'b1;
            end else begin
                tick();
                budget++;
                if (st == 3'(ST_WAIT)) wait_idx++;
                if (st == 3'(ST_RUN)) begin
                    if (stim_done) stim_seen_m = 1'b1;
                    run_idx++;
                end
                if (st == 3'(ST_DRAIN)) drain_idx++;
            end
        end
        chk($sformatf("v%0d_start_level", idx), 32'(start_bad), 32'd0);
        chk($sformatf("v%0d_stim_en_level", idx), 32'(stim_bad), 32'd0);

        // Terminal states must ignore error and inputs, and finish must not repeat.
        if (!aborted) begin
            extra_fin = 0;
            hold_bad  = 0;
            for (int k = 0; k < 5; k++) begin
                error     = 1'b1;
                stim_done = ~stim_done;
                test_done = ~test_done;
                tick();
                if (finish !== 1'b0) extra_fin++;
                if (state !== 3'(v.exp_state)) hold_bad++;
                if ((pass & fail) !== 1'b0) hold_bad++;
                if (pass !== (v.exp_state == ST_PASS)) hold_bad++;
                if (fail !== (v.exp_state == ST_FAIL)) hold_bad++;
                if (timeout !== v.exp_timeout) hold_bad++;
            end
            chk($sformatf("v%0d_extra_finish", idx), 32'(extra_fin), 32'd0);
            chk($sformatf("v%0d_terminal_hold", idx), 32'(hold_bad), 32'd0);
        end
    endtask

    initial begin
        nreset     = 1'b0;
        dut_active = 1'b0;
        stim_done  = 1'b0;
        test_done  = 1'b0;
        error      = 1'b0;

        //            act stim test ew  erun edr abr abd  state     to  run wait drain
        vecs[0]  = mk(3,  50,  60,  0, -1,  -1, -1, -1, ST_PASS,  0,  61, 4,  16);
        vecs[1]  = mk(-1, -1,  -1,  0, -1,  -1, -1, -1, ST_FAIL,  1,  0,  20, 0);
        vecs[2]  = mk(3,  40,  -1,  0, -1,  -1, -1, -1, ST_FAIL,  1,  100, 4, 0);
        vecs[3]  = mk(3,  10,  10,  0, 10,  -1, -1, -1, ST_FAIL,  0,  11, 4,  0);
        vecs[4]  = mk(3,  20,  25,  0, -1,   8, -1, -1, ST_FAIL,  0,  26, 4,  9);
        vecs[5]  = mk(2,  30,  12,  0, -1,  -1, -1, -1, ST_PASS,  0,  31, 3,  16);
        vecs[6]  = mk(0,  99,  99,  0, -1,  -1, -1, -1, ST_PASS,  0,  100, 1, 16);
        vecs[7]  = mk(19, 5,   5,   0, -1,  -1, -1, -1, ST_PASS,  0,  6,  20, 16);
        vecs[8]  = mk(3,  40,  -1,  0, 99,  -1, -1, -1, ST_FAIL,  0,  100, 4, 0);
        vecs[9]  = mk(5,  8,   9,   1, -1,  -1, -1, -1, ST_PASS,  0,  10, 6,  16);
        vecs[10] = mk(3,  50,  60,  0, -1,  -1, 30, -1, ST_IDLE,  0,  0,  4,  0);
        vecs[11] = mk(3,  50,  60,  0, -1,  -1, -1, -1, ST_PASS,  0,  61, 4,  16);
        vecs[12] = mk(3,  10,  10,  0, -1,  -1, -1,  5, ST_IDLE,  0,  0,  4,  5);
        vecs[13] = mk(3,  50,  60,  0, -1,  -1, -1, -1, ST_PASS,  0,  61, 4,  16);

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dv_test_seq.md
DV_TEST_SEQ -- requirements
Module: dv_test_seq

Interface
REQ-001 Parameter ACTIVE_TIMEOUT, default 1000: maximum cycles allowed in WAIT_ACTIVE.
REQ-002 Parameter RUN_TIMEOUT, default 10000: maximum cycles allowed in RUN.
REQ-003 Parameter DRAIN_CYCLES, default 16: cycles spent in DRAIN before PASS; legal range >=1.
REQ-004 Port clk1  input  1  main clock; all state updates on its rising edge.
REQ-005 Port nreset  input  1  reset, asynchronous, active-low.
REQ-006 Port dut_active  input  1  DUT has finished its reset sequence.
REQ-007 Port stim_done  input  1  stimulus source is exhausted.
REQ-008 Port test_done  input  1  checker has seen all expected results.
REQ-009 Port error  input  1  checker mismatch; sampled every cycle.
REQ-010 Port start  output  1  level; test running.
REQ-011 Port stim_en  output  1  enables the stimulus source.
REQ-012 Port finish  output  1  single-cycle pulse on entry to PASS or FAIL.
REQ-013 Port pass  output  1  sticky; test passed.
REQ-014 Port fail  output  1  sticky; test failed.
REQ-015 Port timeout  output  1  sticky; the failure was caused by a timeout.
REQ-016 Port state  output  3  current state encoding.
REQ-017 Port run_cycles  output  32  cycles spent in RUN; saturates at 0xFFFFFFFF.

Function
REQ-018 The block SHALL implement states IDLE=0, WAIT_ACTIVE=1, RUN=2, DRAIN=3, PASS=4 and FAIL=5; codes 6 and 7 SHALL return to IDLE on the next cycle.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then move to WAIT_ACTIVE.
REQ-020 WAIT_ACTIVE SHALL increment a 32-bit wait counter every cycle.
  - dut_active=1 -> RUN on the next edge.
  - Counter reaches ACTIVE_TIMEOUT-1 with dut_active=0 -> FAIL with timeout=1.
  - dut_active=1 on the timeout cycle -> RUN; completion takes priority.
REQ-021 On entry to RUN, the block SHALL clear the watchdog counter and the sticky stim_seen and test_seen flags.
REQ-022 start SHALL be 1 in RUN and DRAIN and 0 in all other states.
REQ-023 stim_en SHALL be 1 in RUN while stim_seen=0.
  - stim_en SHALL drop in the cycle after stim_done is first sampled high.
REQ-024 stim_seen and test_seen SHALL set when stim_done and test_done are sampled high respectively.
  - Once set, they SHALL hold while in RUN.
  - Inputs may rise in either order or in the same cycle.
REQ-025 RUN SHALL move to DRAIN on the edge where (stim_seen|stim_done) & (test_seen|test_done) holds.
REQ-026 RUN SHALL move to FAIL with timeout=1 when the watchdog reaches RUN_TIMEOUT-1 without completion.
REQ-027 run_cycles SHALL increment once per RUN cycle.
  - It SHALL hold its value outside RUN.
  - It SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-028 DRAIN SHALL count DRAIN_CYCLES cycles, then move to PASS.
REQ-029 error=1 in RUN or DRAIN SHALL move to FAIL with timeout=0.
REQ-030 Same-cycle priority SHALL be: error > completion > timeout.
REQ-031 error in IDLE or WAIT_ACTIVE SHALL be ignored.
REQ-032 error in PASS or FAIL SHALL be ignored; those states are terminal until reset.
REQ-033 finish SHALL be 1 for exactly the first cycle in PASS or FAIL.
REQ-034 pass and fail SHALL be set on entry to the terminal state and held; they are never both 1.

Reset
REQ-035 nreset low SHALL asynchronously force the following, in any state, including mid-RUN and mid-DRAIN:
  - state=IDLE
  - start=0, stim_en=0, finish=0
  - pass=0, fail=0, timeout=0
  - run_cycles=0
  - all counters and sticky flags cleared
REQ-036 Reset release SHALL be synchronised to clk1.
  - The block SHALL leave IDLE on the second rising edge of clk1 after nreset rises.

Verification
REQ-037 Normal run: dut_active high 5 cycles after release; stim_done at RUN cycle 50; test_done at RUN cycle 60; DRAIN_CYCLES=16.
  - Expect pass=1, fail=0, one finish pulse, run_cycles=61.
REQ-038 Activation timeout: ACTIVE_TIMEOUT=20, dut_active held 0.
  - Expect FAIL and timeout=1 after 20 WAIT_ACTIVE cycles; start never asserted.
REQ-039 Run timeout: RUN_TIMEOUT=100, test_done never asserted.
  - Expect fail=1, timeout=1, run_cycles=100, and stim_en low after stim_done.
REQ-040 Simultaneous events: error, stim_done and test_done high in the same cycle.
  - Expect FAIL with timeout=0.
  - Separately, error at DRAIN cycle 8 -> expect FAIL.
REQ-041 Reset mid-operation: nreset pulsed low during RUN at cycle 30.
  - Expect all outputs immediately at reset values, then a full normal sequence after release.
